// File: rtl/dr_alm_pkg.sv
// rtl/dr_alm_pkg.sv - shared widths, stage records and keep clamp for the DR-ALM pipe
package dr_alm_pkg;

  localparam int DR_WIDTH      = 16;
  localparam int DR_KEEP_WIDTH = 6;
  localparam int DR_TAG_WIDTH  = 4;
  localparam int K_W           = $clog2(DR_WIDTH);
  localparam int T_W           = $clog2(DR_KEEP_WIDTH + 1);

  typedef struct packed {
    logic                    sign_z;
    logic                    zero;
    logic [K_W-1:0]          k_a;
    logic [K_W-1:0]          k_b;
    logic [DR_WIDTH-1:0]     norm_a;
    logic [DR_WIDTH-1:0]     norm_b;
    logic [T_W-1:0]          t_eff;
    logic [DR_TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic                    sign_z;
    logic                    zero;
    logic [K_W:0]            sum_k;
    logic [DR_KEEP_WIDTH:0]  sum_x;
    logic [T_W-1:0]          t_eff;
    logic [DR_TAG_WIDTH-1:0] tag;
  } s2_t;

  function automatic logic [T_W-1:0] clamp_keep(input logic [T_W-1:0] keep);
    if (keep < T_W'(2)) return T_W'(2);
    if (keep > T_W'(DR_KEEP_WIDTH)) return T_W'(DR_KEEP_WIDTH);
    return keep;
  endfunction

endpackage

// File: rtl/dr_alm_pipe_if.sv
// rtl/dr_alm_pipe_if.sv - operand/result handshake bundle for the DR-ALM pipe
interface dr_alm_pipe_if #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 6,
  parameter int TAG_WIDTH  = 4
);
  logic                              i_valid;
  logic                              o_ready;
  logic [WIDTH-1:0]                  i_a;
  logic [WIDTH-1:0]                  i_b;
  logic                              i_signed;
  logic [$clog2(KEEP_WIDTH+1)-1:0]   i_keep;
  logic [TAG_WIDTH-1:0]              i_tag;
  logic                              o_valid;
  logic                              i_ready;
  logic [2*WIDTH-1:0]                o_z;
  logic [TAG_WIDTH-1:0]              o_tag;

  modport master (
    output i_valid, i_a, i_b, i_signed, i_keep, i_tag, i_ready,
    input  o_ready, o_valid, o_z, o_tag
  );

  modport slave (
    input  i_valid, i_a, i_b, i_signed, i_keep, i_tag, i_ready,
    output o_ready, o_valid, o_z, o_tag
  );
endinterface

// File: rtl/dr_alm_lod.sv
// rtl/dr_alm_lod.sv - priority leading-one detector
module dr_alm_lod #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         x,
  output logic [$clog2(WIDTH)-1:0] k,
  output logic                     any_one
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) k = ($clog2(WIDTH))'(i);
    end
  end

  assign any_one = |x;

endmodule

// File: rtl/dr_alm_pipe.sv
// rtl/dr_alm_pipe.sv - 3-stage dynamic-range approximate log multiplier
// DR_ALM_APPROX_SIGN_EN selects the one's-complement sign path.
module dr_alm_pipe
  import dr_alm_pkg::*;
#(
  parameter int WIDTH      = DR_WIDTH,
  parameter int KEEP_WIDTH = DR_KEEP_WIDTH,
  parameter int TAG_WIDTH  = DR_TAG_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  dr_alm_pipe_if.slave bus
);

  localparam int P_W = 2*WIDTH + KEEP_WIDTH + 1;

  logic               advance;
  logic               s1_valid, s2_valid;
  s1_t                s1_d, s1_q;
  s2_t                s2_d, s2_q;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [K_W-1:0]     k_a, k_b;
  logic               any_a, any_b;
  logic [KEEP_WIDTH-1:0] mask, lsb, x_a, x_b;
  logic               carry;
  logic [KEEP_WIDTH:0] mant;
  logic [K_W:0]       final_k;
  logic [P_W-1:0]     scaled;
  logic [2*WIDTH-1:0] mag, z_d;
  logic [TAG_WIDTH-1:0] tag_d;
  logic               unused_bits;

  assign advance     = !bus.o_valid | bus.i_ready;
  assign bus.o_ready = advance;

  always_comb begin
`ifdef DR_ALM_APPROX_SIGN_EN
    abs_a = bus.i_a ^ {WIDTH{bus.i_signed & bus.i_a[WIDTH-1]}};
    abs_b = bus.i_b ^ {WIDTH{bus.i_signed & bus.i_b[WIDTH-1]}};
`else
    abs_a = (bus.i_signed & bus.i_a[WIDTH-1]) ? -bus.i_a : bus.i_a;
    abs_b = (bus.i_signed & bus.i_b[WIDTH-1]) ? -bus.i_b : bus.i_b;
`endif
  end

  dr_alm_lod #(.WIDTH(WIDTH)) u_lod_a (.x(abs_a), .k(k_a), .any_one(any_a));
  dr_alm_lod #(.WIDTH(WIDTH)) u_lod_b (.x(abs_b), .k(k_b), .any_one(any_b));

  always_comb begin
    s1_d        = '0;
    s1_d.sign_z = bus.i_signed & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
    s1_d.zero   = !any_a | !any_b;
    s1_d.k_a    = k_a;
    s1_d.k_b    = k_b;
    s1_d.norm_a = abs_a << (K_W'(WIDTH-1) - k_a);
    s1_d.norm_b = abs_b << (K_W'(WIDTH-1) - k_b);
    s1_d.t_eff  = clamp_keep(bus.i_keep);
    s1_d.tag    = bus.i_tag;
  end

  // Keep t_eff-1 fraction bits below the implicit one, then force a 1 just under them.
  always_comb begin
    mask = ~({KEEP_WIDTH{1'b1}} >> (s1_q.t_eff - T_W'(1)));
    lsb  = KEEP_WIDTH'(1) << (T_W'(KEEP_WIDTH) - s1_q.t_eff);
    x_a  = (s1_q.norm_a[WIDTH-2 -: KEEP_WIDTH] & mask) | lsb;
    x_b  = (s1_q.norm_b[WIDTH-2 -: KEEP_WIDTH] & mask) | lsb;
    s2_d        = '0;
    s2_d.sign_z = s1_q.sign_z;
    s2_d.zero   = s1_q.zero;
    s2_d.sum_x  = {1'b0, x_a} + {1'b0, x_b};
    s2_d.sum_k  = {1'b0, s1_q.k_a} + {1'b0, s1_q.k_b};
    s2_d.t_eff  = s1_q.t_eff;
    s2_d.tag    = s1_q.tag;
  end

  // mant carries KEEP_WIDTH fraction bits; low KEEP_WIDTH-t_eff bits are always zero.
  always_comb begin
    carry   = s2_q.sum_x[KEEP_WIDTH];
    mant    = carry ? s2_q.sum_x : {1'b1, s2_q.sum_x[KEEP_WIDTH-1:0]};
    final_k = s2_q.sum_k + (K_W+1)'(carry);
    scaled  = P_W'(mant) << final_k;
    mag     = scaled[KEEP_WIDTH +: 2*WIDTH];
    tag_d   = s2_q.tag;
    if (s2_q.zero) begin
      z_d = '0;
    end else if (s2_q.sign_z) begin
`ifdef DR_ALM_APPROX_SIGN_EN
      z_d = ~mag | {{(2*WIDTH-1){1'b0}}, 1'b1};
`else
      z_d = -mag;
`endif
    end else begin
      z_d = mag;
    end
  end

  assign unused_bits = ^{s1_q.norm_a, s1_q.norm_b, scaled, s2_q.t_eff};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_z     <= '0;
      bus.o_tag   <= '0;
    end else if (advance) begin
      s1_valid    <= bus.i_valid;
      s1_q        <= s1_d;
      s2_valid    <= s1_valid;
      s2_q        <= s2_d;
      bus.o_valid <= s2_valid;
      bus.o_z     <= z_d;
      bus.o_tag   <= tag_d;
    end
  end

endmodule

// File: tb/tb_dr_alm_pipe.sv
// tb/tb_dr_alm_pipe.sv - scoreboard bench for the DR-ALM pipe
module tb_dr_alm_pipe;

  localparam int W  = 16;
  localparam int KW = 6;
  localparam int TW = 4;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2:0]     keep;
    logic [TW-1:0]  tag;
    logic [2*W-1:0] exp;
    int             acc;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dr_alm_pipe_if #(.WIDTH(W), .KEEP_WIDTH(KW), .TAG_WIDTH(TW)) bus ();

  dr_alm_pipe #(.WIDTH(W), .KEEP_WIDTH(KW), .TAG_WIDTH(TW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  txn_t stim[$];
  txn_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rdy_rand = 0;
  bit vld_rand = 0;
  bit chk_lat = 1;
  bit prev_stall = 0;
  logic [2*W-1:0] prev_z;
  logic [TW-1:0]  prev_tag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn, input logic [2:0] keep);
    int t, ka, kb;
    longint aa, bb, fa, fb, s, mag;
    logic sz;
    t = (keep < 2) ? 2 : (keep > KW) ? KW : int'(keep);
    if (a == 0 || b == 0) return '0;
    sz = sgn & (a[W-1] ^ b[W-1]);
    aa = (sgn && a[W-1]) ? 65536 - longint'(a) : longint'(a);
    bb = (sgn && b[W-1]) ? 65536 - longint'(b) : longint'(b);
    ka = 0;
    kb = 0;
    for (int i = 0; i < W; i++) begin
      if (aa[i]) ka = i;
      if (bb[i]) kb = i;
    end
    fa = ((aa << (W-1-ka)) >> (W-t)) & ((64'd1 << (t-1)) - 1);
    fb = ((bb << (W-1-kb)) >> (W-t)) & ((64'd1 << (t-1)) - 1);
    s = (fa*2 + 1) + (fb*2 + 1);
    if (s >= (64'd1 << t)) mag = (s << (ka+kb+1)) >> t;
    else mag = (((64'd1 << t) + s) << (ka+kb)) >> t;
    return sz ? 32'(-mag) : 32'(mag);
  endfunction

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                     input logic [2:0] keep, input logic [TW-1:0] tag, input logic [2*W-1:0] exp);
    txn_t e;
    e.a = a; e.b = b; e.sgn = sgn; e.keep = keep; e.tag = tag; e.exp = exp; e.acc = 0;
    stim.push_back(e);
  endtask

  task automatic step();
    txn_t e;
    @(negedge clk);
    cyc++;
    bus.i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stim.size() > 0 && (!vld_rand || $urandom_range(0, 3) != 0)) begin
      bus.i_valid  = 1'b1;
      bus.i_a      = stim[0].a;
      bus.i_b      = stim[0].b;
      bus.i_signed = stim[0].sgn;
      bus.i_keep   = stim[0].keep;
      bus.i_tag    = stim[0].tag;
    end else begin
      bus.i_valid = 1'b0;
    end
    #1;
    if (prev_stall) begin
      check("hold_valid", 64'(bus.o_valid), 64'd1);
      check("hold_z", 64'(bus.o_z), 64'(prev_z));
      check("hold_tag", 64'(bus.o_tag), 64'(prev_tag));
    end
    check("o_ready", 64'(bus.o_ready), 64'(!bus.o_valid | bus.i_ready));
    if (bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("o_z", 64'(bus.o_z), 64'(e.exp));
        check("o_tag", 64'(bus.o_tag), 64'(e.tag));
        if (chk_lat) check("latency", 64'(cyc - e.acc), 64'd3);
      end
    end
    if (bus.i_valid && bus.o_ready) begin
      e = stim.pop_front();
      e.acc = cyc;
      sb.push_back(e);
    end
    prev_stall = bus.o_valid & !bus.i_ready;
    prev_z     = bus.o_z;
    prev_tag   = bus.o_tag;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((stim.size() > 0 || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(stim.size() + sb.size()), 64'd0);
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_signed = 1'b0;
    bus.i_keep = '0; bus.i_tag = '0; bus.i_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_o_z", 64'(bus.o_z), 64'd0);
    check("rst_o_tag", 64'(bus.o_tag), 64'd0);
    check("rst_o_ready", 64'(bus.o_ready), 64'd1);
    rst_n = 1'b1;

    add(16'd3, 16'd3, 1'b1, 3'd5, 4'd1, 32'd8);
    drain(50);

    add(16'd3, 16'd3, 1'b1, 3'd3, 4'd2, 32'd10);
    add(16'd3, 16'd3, 1'b1, 3'd0, 4'd3, model(16'd3, 16'd3, 1'b1, 3'd0));
    add(16'd3, 16'd3, 1'b1, 3'd7, 4'd4, model(16'd3, 16'd3, 1'b1, 3'd7));
    add(16'd3, 16'd3, 1'b1, 3'd2, 4'd5, model(16'd3, 16'd3, 1'b1, 3'd2));
    drain(50);

    add(16'hFFFD, 16'd3, 1'b1, 3'd5, 4'd6, 32'hFFFF_FFF8);
    add(16'h8000, 16'h8000, 1'b1, 3'd5, 4'd7, 32'h4400_0000);
    add(16'hFFFF, 16'd1, 1'b0, 3'd5, 4'd8, 32'h0001_0000);
    add(16'h1234, 16'hF00D, 1'b1, 3'd6, 4'd9, model(16'h1234, 16'hF00D, 1'b1, 3'd6));
    drain(50);

    add(16'd0, 16'd5, 1'b1, 3'd4, 4'hA, 32'd0);
    add(16'd7, 16'd0, 1'b0, 3'd6, 4'hB, 32'd0);
    add(16'd0, 16'd0, 1'b1, 3'd2, 4'hC, 32'd0);
    add(16'd0, 16'h8000, 1'b1, 3'd3, 4'hD, 32'd0);
    drain(50);

    rdy_rand = 1; vld_rand = 1; chk_lat = 0;
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      logic s;
      logic [2:0] kp;
      a  = 16'($urandom);
      b  = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
      s  = 1'($urandom_range(0, 1));
      kp = 3'($urandom_range(0, 7));
      add(a, b, s, kp, 4'(i), model(a, b, s, kp));
    end
    drain(2000);

    rdy_rand = 0; vld_rand = 0;
    add(16'd11, 16'd13, 1'b0, 3'd4, 4'd1, 32'd0);
    add(16'd17, 16'd19, 1'b0, 3'd4, 4'd2, 32'd0);
    add(16'd23, 16'd29, 1'b0, 3'd4, 4'd3, 32'd0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    stim.delete();
    sb.delete();
    prev_stall = 0;
    @(negedge clk);
    #1;
    check("inflight_rst_valid", 64'(bus.o_valid), 64'd0);
    check("inflight_rst_z", 64'(bus.o_z), 64'd0);
    check("inflight_rst_ready", 64'(bus.o_ready), 64'd1);
    rst_n = 1'b1;
    chk_lat = 1;
    add(16'd5, 16'd6, 1'b0, 3'd6, 4'd9, model(16'd5, 16'd6, 1'b0, 3'd6));
    drain(50);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
